booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth signed multiplier in the 16-bit processor datapath.
- Sits directly upstream of the X and A working registers.
- On completion, it drives the low product word and a one-cycle enable into X, and the high word and enable into A.
- The X and A registers bypass input to output while enabled, so the product is visible to the datapath in the write-back cycle itself.

Parameters:
- WIDTH, 16, operand width. Product is 2*WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  WIDTH  signed operand M; captured on the accepting edge
- multiplier  input  WIDTH  signed operand Q; captured on the accepting edge
- busy  output  1  high in RUN and WB
- done  output  1  one-cycle pulse in WB
- x_out  output  WIDTH  low product word; feeds X register data input
- x_en  output  1  X register write enable; high only in WB
- a_out  output  WIDTH  high product word; feeds A register data input
- a_en  output  1  A register write enable; high only in WB
- ovf  output  1  product does not fit in WIDTH signed bits; valid in WB, held afterwards

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_b.
- Reset values:
  - state=IDLE, count=0.
  - Internal accumulator Acc (WIDTH+1 bits), Q, q_m1 and M all 0.
  - busy, done, x_en, a_en, ovf, x_out and a_out all 0.
- States: IDLE, RUN, WB.
- IDLE:
  - busy=0; all enables=0.
  - On an edge with start=1: Acc<=0, Q<=multiplier, q_m1<=0, M<=sign-extend(multiplicand) to WIDTH+1 bits, count<=0, state<=RUN.
  - With start=0: stay in IDLE.
- RUN (exactly WIDTH cycles), at each edge:
  - Select on {Q[0],q_m1}: 01 gives T=Acc+M; 10 gives T=Acc-M; 00 and 11 give T=Acc.
  - Arithmetic right shift of {T,Q,q_m1} by 1. T[WIDTH] is replicated into the MSB.
  - count<=count+1.
  - When count==WIDTH-1 at the edge, state<=WB.
- Width rule: Acc is WIDTH+1 bits so that M=-2^(WIDTH-1) is handled without overflow. The 2*WIDTH product is {Acc[WIDTH-1:0],Q}.
- WB (1 cycle):
  - done=1, x_en=1, a_en=1, busy=1.
  - x_out=Q, a_out=Acc[WIDTH-1:0].
  - ovf=1 iff a_out differs from WIDTH copies of x_out[WIDTH-1].
  - Next edge: state<=IDLE.
- After WB: x_out, a_out and ovf hold their values until the next WB or reset. Enables and done return to 0.
- Latency: with start accepted on edge 0, edges 1..WIDTH perform the steps, so WB is the cycle after edge WIDTH. For WIDTH=16, done is seen 17 edges after acceptance.
- start in RUN or WB is ignored, with no effect on operands. The earliest new acceptance is the first edge after WB.
- Operand changes after acceptance have no effect.
- Reset asserted mid-RUN or in WB returns immediately to reset values. No enable pulse is produced, and a subsequent start operates normally.
- x_en and a_en are never asserted outside WB, so X and A are never written spuriously.

Test Plan:
- 3 x 5 -> x_out=0x000F, a_out=0x0000, ovf=0; done, x_en and a_en high together for exactly one cycle, 17 edges after start is accepted.
- -2 x 7 (0xFFFE, 0x0007) -> x_out=0xFFF2, a_out=0xFFFF, ovf=0.
- 300 x 300 (0x012C, 0x012C) -> x_out=0x5F90, a_out=0x0001, ovf=1.
- 0x8000 x 0x8000 -> x_out=0x0000, a_out=0x4000, ovf=1. 0x8000 x 0x0001 -> x_out=0x8000, a_out=0xFFFF, ovf=0.
- start pulsed with new operands during RUN and during WB -> ignored; the result equals the first operands and only one done pulse occurs. Restart on the edge after WB is accepted.
- rst_b low 8 cycles into RUN -> busy, enables and outputs are 0 immediately with no write pulse. 4 x 4 afterwards -> x_out=0x0010, a_out=0.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier feeding the X (low word) and A (high word)
// working registers with a one-cycle write-back pulse.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic             x_en,
    output logic [WIDTH-1:0] a_out,
    output logic             a_en,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH:0]    acc_q, acc_d;
    logic [WIDTH:0]    m_q, m_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              qm1_q, qm1_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  x_out_q, x_out_d;
    logic [WIDTH-1:0]  a_out_q, a_out_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH:0]    t;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        x_out_d = x_out_q;
        a_out_d = a_out_q;
        ovf_d   = ovf_q;

        case ({q_q[0], qm1_q})
            2'b01:   t = acc_q + m_q;
            2'b10:   t = acc_q - m_q;
            default: t = acc_q;
        endcase

        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Arithmetic right shift of {T, Q, q_m1}
                acc_d   = {t[WIDTH], t[WIDTH:1]};
                q_d     = {t[0], q_q[WIDTH-1:1]};
                qm1_d   = q_q[0];
                count_d = count_q + CntW'(1);
                if (count_q == CntW'(WIDTH - 1)) begin
                    state_d = StWb;
                    done_d  = 1'b1;
                    x_out_d = q_d;
                    a_out_d = acc_d[WIDTH-1:0];
                    ovf_d   = (acc_d[WIDTH-1:0] != {WIDTH{q_d[WIDTH-1]}});
                end
            end
            StWb: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            count_q <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_out_q <= '0;
            a_out_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x_out_q <= x_out_d;
            a_out_q <= a_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign x_en  = done_q;
    assign a_en  = done_q;
    assign x_out = x_out_q;
    assign a_out = a_out_q;
    assign ovf   = ovf_q;

endmodule
